mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 16-bit 8-to-1 select datapath among 8 requesters.
- Drives the three mux select lines (s2, s1, s0) and a one-hot grant vector.
- Presents a valid/ready beat handshake to the single downstream consumer of the mux output.
- Bounds each grant to a maximum burst so that no requester can starve the others.

---
 rtl/mux8_rr_arbiter_pkg.sv | 23 ++
 rtl/mux8_rr_arbiter_if.sv | 35 +++
 rtl/mux8_rr_arbiter_rr_pick8.sv | 42 ++++
 rtl/mux8_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter_pkg
// Purpose  : Shared constants and helpers for the 8-way round-robin
//            mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux8_rr_arbiter_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  // Arbiter state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Convert a requester index into its one-hot grant pattern
  function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux8_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter_if
// Purpose  : Request / grant / select / beat-handshake bundle between the
//            arbiter and its requesters plus downstream consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface mux8_rr_arbiter_if #(
  parameter int CNT_W = 4
) ();
  import mux8_rr_arbiter_pkg::*;

  logic [NREQ-1:0]  req;
  logic             out_ready;
  logic [NREQ-1:0]  grant;
  logic             s2;
  logic             s1;
  logic             s0;
  logic             out_valid;
  logic [CNT_W-1:0] beat_cnt;

  // Arbiter side
  modport master (
    input  req, out_ready,
    output grant, s2, s1, s0, out_valid, beat_cnt
  );

  // Requesters and downstream consumer side
  modport slave (
    output req, out_ready,
    input  grant, s2, s1, s0, out_valid, beat_cnt
  );

endinterface
`default_nettype wire

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick8
// Purpose  : Combinational round-robin pick. Rotates req so the index after
//            last_idx sits at bit 0, priority-encodes the lowest set bit and
//            rotates the result back to an absolute index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [IDX_W-1:0] start_idx;
  logic [NREQ-1:0]  req_rot;
  logic [IDX_W-1:0] offset;

  // Rotate, priority-encode lowest set bit, then un-rotate
  always_comb begin
    start_idx = last_idx + IDX_W'(1);
    req_rot   = '0;
    offset    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // 3-bit addition wraps mod 8, so bit k is requester (last_idx+1+k)
      req_rot[k] = req[start_idx + IDX_W'(k)];
    end
    // Scanning downward lets the lowest set bit win
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = IDX_W'(k);
      end
    end
    pick_vld = |req_rot;
    pick_idx = start_idx + offset;
  end

endmodule
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter
// Purpose  : Round-robin arbiter sharing one 8-to-1 mux among 8 requesters,
//            with a valid/ready beat handshake and a bounded burst per grant.
// Revision : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux8_rr_arbiter_if.master   bus
);

  logic [0:0]       state_q,    state_d;
  logic [IDX_W-1:0] gnt_idx_q,  gnt_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [NREQ-1:0]  grant_q,    grant_d;

  logic             out_valid;
  logic             beat;
  logic             last_beat;
  logic             grant_end;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  // At end of grant the pointer moves to the current holder in the same
  // cycle, so the pick already sees the updated pointer.
  assign pick_ptr = (state_q == ST_BUSY) ? gnt_idx_q : last_idx_q;

  rr_pick8 u_pick (
    .req      (bus.req),
    .last_idx (pick_ptr),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= IDX_W'(NREQ - 1);
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
    end
  end

  // Next state: arbitrate from IDLE, count beats and re-arbitrate in BUSY
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d    = ST_BUSY;
          gnt_idx_d  = pick_idx;
          beat_cnt_d = '0;
          grant_d    = idx2onehot(pick_idx);
        end
      end
      ST_BUSY: begin
        if (grant_end) begin
          last_idx_d = gnt_idx_q;
          beat_cnt_d = '0;
          if (pick_vld) begin
            gnt_idx_d = pick_idx;
            grant_d   = idx2onehot(pick_idx);
          end else begin
            // Select lines keep the last index because gnt_idx holds
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: handshake is combinational from the registered grant index
  always_comb begin
    out_valid = (state_q == ST_BUSY) && bus.req[gnt_idx_q];
    beat      = out_valid && bus.out_ready;
    last_beat = beat && (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    grant_end = (state_q == ST_BUSY) && (!bus.req[gnt_idx_q] || last_beat);
  end

  assign bus.grant              = grant_q;
  assign {bus.s2, bus.s1, bus.s0} = gnt_idx_q;
  assign bus.out_valid          = out_valid;
  assign bus.beat_cnt           = beat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8_rr_arbiter
// Purpose  : Self-checking bench for mux8_rr_arbiter: table of per-cycle
//            vectors plus hand-written rotation and stall sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_arbiter;

  typedef struct packed {
    logic       rst_n;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] exp_grant;
    logic [2:0] exp_sel;
    logic       exp_valid;
    logic [3:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  mux8_rr_arbiter_if #(.CNT_W(4)) bus ();

  mux8_rr_arbiter #(.MAX_BEATS(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [7:0] g, input logic [2:0] s,
                           input logic v, input logic [3:0] c);
    check("grant", idx, 32'(bus.grant), 32'(g));
    check("sel", idx, 32'({bus.s2, bus.s1, bus.s0}), 32'(s));
    check("out_valid", idx, 32'(bus.out_valid), 32'(v));
    check("beat_cnt", idx, 32'(bus.beat_cnt), 32'(c));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [7:0] q, input logic rd,
                     input logic [7:0] g, input logic [2:0] s, input logic v,
                     input logic [3:0] c);
    vec_t t;
    t = '{rst_n: r, req: q, rdy: rd, exp_grant: g, exp_sel: s,
          exp_valid: v, exp_cnt: c};
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 8'h00;
    bus.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = 8'h00;
    bus.out_ready = 1'b1;

    // Single requester 0: grant after one cycle, 4 beats, then re-granted
    add(0, 8'h00, 1, 8'h00, 3'd0, 0, 4'd0);
    add(1, 8'h01, 1, 8'h01, 3'd0, 1, 4'd0);
    add(1, 8'h01, 1, 8'h01, 3'd0, 1, 4'd1);
    add(1, 8'h01, 1, 8'h01, 3'd0, 1, 4'd2);
    add(1, 8'h01, 1, 8'h01, 3'd0, 1, 4'd3);
    add(1, 8'h01, 1, 8'h01, 3'd0, 1, 4'd0);
    add(1, 8'h01, 1, 8'h01, 3'd0, 1, 4'd1);
    // Grant to 2, release after one beat, hand-over to 5
    add(0, 8'h00, 1, 8'h00, 3'd0, 0, 4'd0);
    add(1, 8'h24, 1, 8'h04, 3'd2, 1, 4'd0);
    add(1, 8'h24, 1, 8'h04, 3'd2, 1, 4'd1);
    add(1, 8'h20, 1, 8'h20, 3'd5, 1, 4'd0);
    // Grant to 3, reset at beat_cnt 2, requester 0 wins afterwards
    add(0, 8'h00, 1, 8'h00, 3'd0, 0, 4'd0);
    add(1, 8'h08, 1, 8'h08, 3'd3, 1, 4'd0);
    add(1, 8'h08, 1, 8'h08, 3'd3, 1, 4'd1);
    add(1, 8'h08, 1, 8'h08, 3'd3, 1, 4'd2);
    add(0, 8'h09, 1, 8'h00, 3'd0, 0, 4'd0);
    add(1, 8'h09, 1, 8'h01, 3'd0, 1, 4'd0);
    // Grant to 4, all requests drop at the last beat, sel holds in IDLE
    add(0, 8'h00, 1, 8'h00, 3'd0, 0, 4'd0);
    add(1, 8'h10, 1, 8'h10, 3'd4, 1, 4'd0);
    add(1, 8'h10, 1, 8'h10, 3'd4, 1, 4'd1);
    add(1, 8'h10, 1, 8'h10, 3'd4, 1, 4'd2);
    add(1, 8'h10, 1, 8'h10, 3'd4, 1, 4'd3);
    add(1, 8'h00, 1, 8'h00, 3'd4, 0, 4'd0);
    add(1, 8'h00, 1, 8'h00, 3'd4, 0, 4'd0);
    // Non-granted requester toggling does not preempt holder 1
    add(0, 8'h00, 1, 8'h00, 3'd0, 0, 4'd0);
    add(1, 8'h02, 1, 8'h02, 3'd1, 1, 4'd0);
    add(1, 8'h03, 1, 8'h02, 3'd1, 1, 4'd1);
    add(1, 8'h82, 1, 8'h02, 3'd1, 1, 4'd2);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      bus.req = vecs[i].req;
      bus.out_ready = vecs[i].rdy;
      step();
      check_all(i, vecs[i].exp_grant, vecs[i].exp_sel, vecs[i].exp_valid,
                vecs[i].exp_cnt);
    end

    // All requesting: grants rotate 0..7,0 with exactly 4 beats each
    do_reset();
    bus.req = 8'hFF;
    step();
    for (int g = 0; g < 9; g++) begin
      for (int b = 0; b < 4; b++) begin
        check_all(100 + g * 4 + b, 8'h01 << (g % 8), 3'(g % 8), 1'b1, 4'(b));
        step();
      end
    end

    // Stall: grant to 6 held with out_ready low for 10 cycles
    do_reset();
    bus.req = 8'h40;
    bus.out_ready = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      check_all(200 + k, 8'h40, 3'd6, 1'b1, 4'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check_all(210, 8'h40, 3'd6, 1'b1, 4'd1);
    step();
    check_all(211, 8'h40, 3'd6, 1'b1, 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
